// File: rtl/lvds_frame_align_pkg.sv
// Shared definitions for the LVDS frame-lane bitslip training controller:
// FSM state encoding, default frame patterns and a saturating-increment helper.
package lvds_align_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_SLIP   = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } align_state_e;

    // Frame-clock lane word as seen by a correctly aligned deserializer
    localparam logic [7:0] FRAME_PATTERN_1LANE = 8'hF0;
    localparam logic [7:0] FRAME_PATTERN_2LANE = 8'hCC;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/lvds_frame_align_if.sv
// Handshake/status bundle between the lane PHY side and the alignment controller.
interface lvds_frame_align_if;
    logic       start;
    logic [7:0] din;
    logic       bitslip;
    logic       busy;
    logic       locked;
    logic       fail;
    logic [2:0] slip_count;
    logic [7:0] relock_count;

    modport master (
        output start, din,
        input  bitslip, busy, locked, fail, slip_count, relock_count
    );

    modport slave (
        input  start, din,
        output bitslip, busy, locked, fail, slip_count, relock_count
    );
endinterface

// File: rtl/lvds_frame_align_match_run_counter.sv
// Consecutive-event counter: counts inc cycles, saturates at TERM, and flags the
// increment that reaches TERM. A cycle without inc (or with clr) restarts the run.
module match_run_counter #(
    parameter int unsigned TERM = 16
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic hit_o
);
    localparam logic [7:0] TERM_W  = 8'(TERM);
    localparam logic [7:0] TERM_M1 = 8'(TERM - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next run length
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (inc_i && (cnt_q != TERM_W)) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign hit_o = inc_i && !clr_i && (cnt_q >= TERM_M1);

    // Run length register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/lvds_frame_align.sv
// Bitslip training controller for one 8-bit LVDS lane: slips the PHY until the
// word matches PATTERN for MATCH_N cycles, then monitors and retrains on loss.
module lvds_frame_align
    import lvds_align_pkg::*;
#(
    parameter logic [7:0]  PATTERN = FRAME_PATTERN_1LANE,
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned MATCH_N = 16,
    parameter int unsigned LOSS_N  = 4
) (
    input  logic               clk_div,
    input  logic               reset,
    lvds_frame_align_if.slave  bus
);
    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    align_state_e state_q, state_d;
    logic [3:0]   settle_q, settle_d;
    logic [2:0]   try_q, try_d;
    logic [2:0]   slip_cnt_q, slip_cnt_d;
    logic [7:0]   relock_q, relock_d;
    logic         bitslip_q, busy_q, locked_q, fail_q;

    logic is_match_s;
    logic match_inc_s, loss_inc_s;
    logic match_hit_s, loss_hit_s;
    logic start_ok_s;

    assign is_match_s  = (bus.din == PATTERN);
    assign match_inc_s = (state_q == ST_CHECK) && is_match_s;
    assign loss_inc_s  = (state_q == ST_LOCKED) && !is_match_s;
    assign start_ok_s  = bus.start && ((state_q == ST_IDLE) || (state_q == ST_LOCKED) ||
                                       (state_q == ST_FAIL));

    match_run_counter #(.TERM(MATCH_N)) u_match_run (
        .clk_i   (clk_div),
        .reset_i (reset),
        .clr_i   (!match_inc_s),
        .inc_i   (match_inc_s),
        .hit_o   (match_hit_s)
    );

    match_run_counter #(.TERM(LOSS_N)) u_loss_run (
        .clk_i   (clk_div),
        .reset_i (reset),
        .clr_i   (!loss_inc_s),
        .inc_i   (loss_inc_s),
        .hit_o   (loss_hit_s)
    );

    // Training FSM next state; a start in a resting state overrides everything,
    // including a simultaneous loss of lock
    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        try_d      = try_q;
        slip_cnt_d = slip_cnt_q;
        relock_d   = relock_q;
        if (start_ok_s) begin
            state_d    = ST_SETTLE;
            settle_d   = SETTLE_M1;
            try_d      = 3'd0;
            slip_cnt_d = 3'd0;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    if (settle_q == 4'd0) begin
                        state_d = ST_CHECK;
                    end else begin
                        settle_d = settle_q - 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (match_hit_s) begin
                        state_d = ST_LOCKED;
                    end else if (!is_match_s) begin
                        state_d = (try_q != 3'd7) ? ST_SLIP : ST_FAIL;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
                ST_SLIP: begin
                    state_d    = ST_SETTLE;
                    settle_d   = SETTLE_M1;
                    try_d      = try_q + 3'd1;
                    slip_cnt_d = slip_cnt_q + 3'd1;
                end
                ST_LOCKED: begin
                    if (loss_hit_s) begin
                        state_d  = ST_SETTLE;
                        settle_d = SETTLE_M1;
                        try_d    = 3'd0;
                        relock_d = sat_inc8(relock_q);
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State, counters and outputs, all derived from the next state so they are registered
    always_ff @(posedge clk_div) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            settle_q   <= 4'd0;
            try_q      <= 3'd0;
            slip_cnt_q <= 3'd0;
            relock_q   <= 8'd0;
            bitslip_q  <= 1'b0;
            busy_q     <= 1'b0;
            locked_q   <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            try_q      <= try_d;
            slip_cnt_q <= slip_cnt_d;
            relock_q   <= relock_d;
            bitslip_q  <= (state_d == ST_SLIP);
            busy_q     <= (state_d == ST_SETTLE) || (state_d == ST_CHECK) || (state_d == ST_SLIP);
            locked_q   <= (state_d == ST_LOCKED);
            fail_q     <= (state_d == ST_FAIL);
        end
    end

    assign bus.bitslip      = bitslip_q;
    assign bus.busy         = busy_q;
    assign bus.locked       = locked_q;
    assign bus.fail         = fail_q;
    assign bus.slip_count   = slip_cnt_q;
    assign bus.relock_count = relock_q;
endmodule

// File: tb/tb_lvds_frame_align.sv
// Directed bench for lvds_frame_align: a rotating-word PHY model answers bitslip
// pulses; each scenario checks hand-computed timing and counter values.
`timescale 1ns/1ps
module tb_lvds_frame_align;
    localparam logic [7:0] PAT = 8'hF0;

    logic clk_div = 1'b0;
    logic reset;
    lvds_frame_align_if bus();

    lvds_frame_align #(.PATTERN(PAT), .SETTLE(4), .MATCH_N(16), .LOSS_N(4)) dut (
        .clk_div (clk_div),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_div = ~clk_div;

    // PHY model: word is PAT rotated by (base_off + pulses seen); zero when forced
    logic [2:0] base_off = 3'd0;
    logic       force_zero = 1'b0;
    int         cyc = 0;
    int         pulse_total = 0;
    int         last_pulse = -100;
    int         gap_viol = 0;
    logic [2:0] eff_off;

    function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] k);
        logic [15:0] w;
        w = {v, v} << k;
        return w[15:8];
    endfunction

    assign eff_off = base_off + 3'(pulse_total);
    assign bus.din = force_zero ? 8'h00 : rotl8(PAT, eff_off);

    always @(posedge clk_div) begin
        cyc <= cyc + 1;
        if (bus.bitslip === 1'b1) begin
            pulse_total <= pulse_total + 1;
            if (cyc - last_pulse < 6) gap_viol <= gap_viol + 1;
            last_pulse <= cyc;
        end
    end

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_div);
            #1;
        end
    endtask

    // The word will be aligned after exactly k further slips
    task automatic set_need(input int k);
        base_off = 3'(-k - pulse_total);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic wait_locked(input int budget);
        int n;
        n = 0;
        while (bus.locked !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_bitslip"}, 32'(bus.bitslip), 32'd0);
        check_val({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check_val({tag, "_locked"}, 32'(bus.locked), 32'd0);
        check_val({tag, "_fail"}, 32'(bus.fail), 32'd0);
        check_val({tag, "_slipcnt"}, 32'(bus.slip_count), 32'd0);
        check_val({tag, "_relock"}, 32'(bus.relock_count), 32'd0);
    endtask

    initial begin
        int p0;
        int n;
        bus.start = 1'b0;
        reset     = 1'b1;
        tick(3);
        check_all_zero("rst");
        reset = 1'b0;
        tick(2);
        check_val("idle_busy", 32'(bus.busy), 32'd0);

        // Aligned from start: locked exactly 21 cycles after the start cycle
        set_need(0);
        p0 = pulse_total;
        pulse_start();
        check_val("al_busy", 32'(bus.busy), 32'd1);
        tick(19);
        check_val("al_locked_c20", 32'(bus.locked), 32'd0);
        tick(1);
        check_val("al_locked_c21", 32'(bus.locked), 32'd1);
        check_val("al_busy_c21", 32'(bus.busy), 32'd0);
        check_val("al_pulses", 32'(pulse_total - p0), 32'd0);
        check_val("al_slipcnt", 32'(bus.slip_count), 32'd0);

        // Misaligned by 5 positions: three slips bring it home
        set_need(3);
        p0 = pulse_total;
        pulse_start();
        wait_locked(200);
        check_val("o5_locked", 32'(bus.locked), 32'd1);
        check_val("o5_pulses", 32'(pulse_total - p0), 32'd3);
        check_val("o5_gap", 32'(gap_viol), 32'd0);
        check_val("o5_slipcnt", 32'(bus.slip_count), 32'd3);

        // Glitch of three mismatches does not drop lock
        tick(2);
        force_zero = 1'b1;
        tick(3);
        check_val("gl_hold3", 32'(bus.locked), 32'd1);
        force_zero = 1'b0;
        tick(1);
        check_val("gl_hold_after", 32'(bus.locked), 32'd1);
        check_val("gl_relock", 32'(bus.relock_count), 32'd0);

        // Four consecutive mismatches: lock drops on the 4th sampling edge
        force_zero = 1'b1;
        tick(3);
        check_val("ls_hold3", 32'(bus.locked), 32'd1);
        tick(1);
        check_val("ls_drop", 32'(bus.locked), 32'd0);
        check_val("ls_relock", 32'(bus.relock_count), 32'd1);
        check_val("ls_busy", 32'(bus.busy), 32'd1);
        force_zero = 1'b0;
        set_need(2);
        p0 = pulse_total;
        wait_locked(200);
        check_val("ls_relocked", 32'(bus.locked), 32'd1);
        check_val("ls_pulses", 32'(pulse_total - p0), 32'd2);
        check_val("ls_slipcnt", 32'(bus.slip_count), 32'd5);
        check_val("ls_gap", 32'(gap_viol), 32'd0);

        // No valid position: seven slips then fail, and it stays quiet
        force_zero = 1'b1;
        p0 = pulse_total;
        pulse_start();
        n = 0;
        while (bus.fail !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        check_val("nv_fail", 32'(bus.fail), 32'd1);
        check_val("nv_locked", 32'(bus.locked), 32'd0);
        check_val("nv_busy", 32'(bus.busy), 32'd0);
        check_val("nv_pulses", 32'(pulse_total - p0), 32'd7);
        check_val("nv_slipcnt", 32'(bus.slip_count), 32'd7);
        tick(1000);
        check_val("nv_quiet", 32'(pulse_total - p0), 32'd7);
        check_val("nv_fail_hold", 32'(bus.fail), 32'd1);

        // Start during CHECK is ignored: lock time is unchanged
        force_zero = 1'b0;
        set_need(0);
        pulse_start();
        check_val("sc_fail_clr", 32'(bus.fail), 32'd0);
        tick(6);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        check_val("sc_busy", 32'(bus.busy), 32'd1);
        tick(12);
        check_val("sc_locked_c20", 32'(bus.locked), 32'd0);
        tick(1);
        check_val("sc_locked_c21", 32'(bus.locked), 32'd1);
        check_val("sc_slipcnt", 32'(bus.slip_count), 32'd0);
        check_val("sc_relock", 32'(bus.relock_count), 32'd1);

        // Reset in the cycle after a bitslip pulse
        set_need(4);
        p0 = pulse_total;
        pulse_start();
        n = 0;
        while (bus.bitslip !== 1'b1 && n < 50) begin
            tick(1);
            n++;
        end
        check_val("rs_pulse_seen", 32'(bus.bitslip), 32'd1);
        tick(1);
        reset = 1'b1;
        tick(1);
        check_all_zero("rs");
        reset = 1'b0;
        p0 = pulse_total;
        tick(60);
        check_val("rs_no_pulse", 32'(pulse_total - p0), 32'd0);
        check_val("rs_idle_busy", 32'(bus.busy), 32'd0);

        // Fresh start after reset finishes the remaining three slips
        pulse_start();
        wait_locked(200);
        check_val("rs_relocked", 32'(bus.locked), 32'd1);
        check_val("rs_pulses", 32'(pulse_total - p0), 32'd3);
        check_val("rs_slipcnt", 32'(bus.slip_count), 32'd3);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
